// File: rtl/saes_stream_if.sv
// Request/result handshake bundle for the S-AES stream core.
// master drives requests and result-ready; slave is the core.
interface saes_stream_if #(
  parameter int CHANNELS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_mode;
  logic [15:0]           in_key;
  logic [16*CHANNELS-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_mode;
  logic [16*CHANNELS-1:0] out_data;

  modport master (
    output in_valid, in_mode, in_key, in_data, out_ready,
    input  in_ready, out_valid, out_mode, out_data
  );

  modport slave (
    input  in_valid, in_mode, in_key, in_data, out_ready,
    output in_ready, out_valid, out_mode, out_data
  );
endinterface

// File: rtl/saes_stream_core.sv
// Iterative S-AES encrypt/decrypt engine with cached key schedule.
// Ports: clk, rst_n (async low), bus (saes_stream_if.slave).
module saes_stream_core #(
  parameter int CHANNELS = 4
) (
  input logic         clk,
  input logic         rst_n,
  saes_stream_if.slave bus
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CW-1:0] CH_LAST = CW'(CHANNELS - 1);

  typedef enum logic [2:0] {
    IDLE, KEY1, KEY2, RUN, DONE
  } state_t;

  state_t st, nxt;

  logic [15:0] key_reg, k1, k2;
  logic        kvalid;
  logic        mode_reg;
  logic [16*CHANNELS-1:0] data_reg;
  logic [16*CHANNELS-1:0] odata;
  logic        omode;
  logic [CW-1:0] ch;
  logic [1:0]  ph;
  logic [15:0] s, s_nx, res, blk;
  logic [7:0]  w2, w3, w4, w5;
  logic        hit, accept;

  function automatic logic [3:0] sbox(
    input logic [3:0] n,
    input logic       inv
  );
    logic [63:0] t;
    t = inv ? 64'hED4C_3206_F871_B95A
            : 64'h7FEC_3026_581D_BA49;
    return t[{n, 2'b00} +: 4];
  endfunction

  function automatic logic [15:0] sub16(
    input logic [15:0] x,
    input logic        inv
  );
    return {sbox(x[15:12], inv), sbox(x[11:8], inv),
            sbox(x[7:4], inv), sbox(x[3:0], inv)};
  endfunction

  // ShiftRow is its own inverse.
  function automatic logic [15:0] shr(input logic [15:0] x);
    return {x[15:12], x[3:0], x[7:4], x[11:8]};
  endfunction

  function automatic logic [3:0] gm(
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [3:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  function automatic logic [15:0] mix(
    input logic [15:0] x,
    input logic        inv
  );
    logic [3:0] a, b;
    a = inv ? 4'h9 : 4'h1;
    b = inv ? 4'h2 : 4'h4;
    return {gm(a, x[15:12]) ^ gm(b, x[11:8]),
            gm(b, x[15:12]) ^ gm(a, x[11:8]),
            gm(a, x[7:4]) ^ gm(b, x[3:0]),
            gm(b, x[7:4]) ^ gm(a, x[3:0])};
  endfunction

  // SubNib(RotNib(w)) on a key byte.
  function automatic logic [7:0] gfun(input logic [7:0] w);
    return {sbox(w[3:0], 1'b0), sbox(w[7:4], 1'b0)};
  endfunction

  assign hit    = kvalid && (bus.in_key == key_reg);
  assign accept = bus.in_valid && (st == IDLE);

  assign bus.in_ready  = (st == IDLE);
  assign bus.out_valid = (st == DONE);
  assign bus.out_mode  = omode;
  assign bus.out_data  = odata;

  assign w2 = key_reg[15:8] ^ 8'h80 ^ gfun(key_reg[7:0]);
  assign w3 = w2 ^ key_reg[7:0];
  assign w4 = k1[15:8] ^ 8'h30 ^ gfun(k1[7:0]);
  assign w5 = w4 ^ k1[7:0];

  always_comb begin
    blk = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (ch == CW'(i)) blk = data_reg[16*i +: 16];
  end

  always_comb begin
    s_nx = s;
    res  = '0;
    case (ph)
      2'd0: s_nx = mode_reg ? (blk ^ key_reg)
                            : sub16(shr(blk ^ k2), 1'b1);
      2'd1: s_nx = mode_reg ? (mix(shr(sub16(s, 1'b0)), 1'b0) ^ k1)
                            : mix(s ^ k1, 1'b1);
      default: res = mode_reg ? (shr(sub16(s, 1'b0)) ^ k2)
                              : (sub16(shr(s), 1'b1) ^ key_reg);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= nxt;
  end

  always_comb begin
    nxt = st;
    unique case (st)
      IDLE: if (bus.in_valid) nxt = hit ? RUN : KEY1;
      KEY1: nxt = KEY2;
      KEY2: nxt = RUN;
      RUN:  if (ph == 2'd2 && ch == CH_LAST) nxt = DONE;
      DONE: if (bus.out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg  <= '0;
      k1       <= '0;
      k2       <= '0;
      kvalid   <= 1'b0;
      mode_reg <= 1'b0;
      data_reg <= '0;
      odata    <= '0;
      omode    <= 1'b0;
      ch       <= '0;
      ph       <= '0;
      s        <= '0;
    end else begin
      if (accept) begin
        mode_reg <= bus.in_mode;
        data_reg <= bus.in_data;
        if (!hit) begin
          key_reg <= bus.in_key;
          kvalid  <= 1'b0;
        end
      end
      if (st == KEY1) k1 <= {w2, w3};
      if (st == KEY2) begin
        k2     <= {w4, w5};
        kvalid <= 1'b1;
      end
      if (st == RUN) begin
        s <= s_nx;
        if (ph == 2'd2) begin
          for (int i = 0; i < CHANNELS; i++)
            if (ch == CW'(i)) odata[16*i +: 16] <= res;
          ph <= '0;
          if (ch == CH_LAST) begin
            ch    <= '0;
            omode <= mode_reg;
          end else begin
            ch <= ch + CW'(1);
          end
        end else begin
          ph <= ph + 2'd1;
        end
      end
    end
  end

endmodule
